// File: rtl/core_mem_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | core_mem_sequencer                                                     |
// | Shares one variable-latency memory port between fetch and LDR/STR data |
// | access, pulsing core_en once per committed instruction.                |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module core_mem_sequencer #(
  parameter int bus       = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [bus-1:0] pc_out,
  input  logic           MRE,
  input  logic           MWE,
  input  logic [bus-1:0] memdir,
  input  logic [bus-1:0] memdataout,
  output logic [bus-1:0] instruction,
  output logic [bus-1:0] memdatain,
  output logic           core_en,
  output logic           mem_req,
  output logic           mem_we,
  output logic [bus-1:0] mem_addr,
  output logic [bus-1:0] mem_wdata,
  input  logic [bus-1:0] mem_rdata,
  input  logic           mem_ready,
  input  logic           halt_req,
  output logic           halted,
  output logic [1:0]     err,
  output logic [31:0]    retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_DATA   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5,
    S_ERROR  = 3'd6
  } state_t;

  state_t               state_q, state_d;
  logic [bus-1:0]       instr_q, instr_d;
  logic [bus-1:0]       memdatain_q, memdatain_d;
  logic [bus-1:0]       addr_q, addr_d;
  logic [bus-1:0]       wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 req_q, req_d;
  logic                 core_en_q, core_en_d;
  logic                 halted_q, halted_d;
  logic [1:0]           err_q, err_d;
  logic [31:0]          retired_q, retired_d;
  logic [TIMEOUT_W-1:0] wait_q, wait_d;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    memdatain_d = memdatain_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    err_d       = err_q;
    retired_d   = retired_q;
    wait_d      = wait_q;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          instr_d = mem_rdata;
          state_d = S_EXEC;
        end else if (&wait_q) begin
          err_d   = 2'b01;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      S_EXEC: begin
        if (MRE && MWE) begin
          err_d   = 2'b11;
          state_d = S_ERROR;
        end else if (MRE || MWE) begin
          addr_d  = memdir;
          wdata_d = memdataout;
          we_d    = MWE;
          state_d = S_DATA;
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_DATA: begin
        if (mem_ready) begin
          if (!we_q) memdatain_d = mem_rdata;
          state_d = S_COMMIT;
        end else if (&wait_q) begin
          err_d   = 2'b10;
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + TIMEOUT_W'(1);
        end
      end
      S_COMMIT: begin
        retired_d = retired_q + 32'd1;
        state_d   = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:  if (!halt_req) state_d = S_FETCH;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    // Every path into a request state comes from a different state, so this is "on entry".
    if ((state_d == S_FETCH || state_d == S_DATA) && state_d != state_q) wait_d = '0;
    if (state_d != S_DATA) we_d = 1'b0;
    req_d     = (state_d == S_FETCH) || (state_d == S_DATA);
    core_en_d = (state_d == S_COMMIT);
    halted_d  = (state_d == S_HALT) || (state_d == S_ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      memdatain_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      req_q       <= 1'b0;
      core_en_q   <= 1'b0;
      halted_q    <= 1'b0;
      err_q       <= 2'b00;
      retired_q   <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      memdatain_q <= memdatain_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      req_q       <= req_d;
      core_en_q   <= core_en_d;
      halted_q    <= halted_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
      wait_q      <= wait_d;
    end
  end

  // pc_out only moves at the COMMIT edge, so fetch drives it straight through.
  assign mem_addr    = (state_q == S_FETCH) ? pc_out : addr_q;
  assign instruction = instr_q;
  assign memdatain   = memdatain_q;
  assign core_en     = core_en_q;
  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_wdata   = wdata_q;
  assign halted      = halted_q;
  assign err         = err_q;
  assign retired     = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_core_mem_sequencer                                                  |
// | Directed checks of fetch, LDR/STR, halt, timeout and reset behaviour.  |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_core_mem_sequencer;

  localparam logic [31:0] c_ALU = 32'hE081_2003;
  localparam logic [31:0] c_LDR = 32'hE590_1000;
  localparam logic [31:0] c_STR = 32'hE581_2000;

  logic        clk, reset;
  logic [31:0] pc_out, memdir, memdataout, mem_rdata;
  logic        MRE, MWE, mem_ready, halt_req;
  logic [31:0] instruction, memdatain, mem_addr, mem_wdata, retired;
  logic        core_en, mem_req, mem_we, halted;
  logic [1:0]  err;

  int errors = 0;
  int checks = 0;

  core_mem_sequencer #(.bus(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .MRE(MRE), .MWE(MWE),
    .memdir(memdir), .memdataout(memdataout), .instruction(instruction),
    .memdatain(memdatain), .core_en(core_en), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .halt_req(halt_req), .halted(halted), .err(err),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; pc_out = 32'h0;
    step(); step();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", mem_req); end
    checks++; if (core_en !== 1'b0) begin errors++; $display("FAIL rst_core_en: got %b expected 0", core_en); end
    checks++; if ({halted, mem_we, err} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b expected 0000", {halted, mem_we, err}); end
    checks++; if (retired !== 32'h0) begin errors++; $display("FAIL rst_retired: got %h expected 0", retired); end
    checks++; if ({instruction, memdatain, mem_addr, mem_wdata} !== 128'h0) begin errors++; $display("FAIL rst_regs: got %h expected 0", {instruction, memdatain, mem_addr, mem_wdata}); end
    reset = 1'b1;
    step();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_first_fetch: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_fetch_addr: got %h/%b expected 0/0", mem_addr, mem_we); end
  endtask

  // Entry/exit point of every instruction task: negedge of the first FETCH cycle.
  task automatic test_alu();
    mem_rdata = c_ALU; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    checks++; if (mem_req !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL alu_exec: got req=%b en=%b expected 0/0", mem_req, core_en); end
    checks++; if (instruction !== c_ALU) begin errors++; $display("FAIL alu_instr: got %h expected %h", instruction, c_ALU); end
    step();
    checks++; if (core_en !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL alu_commit: got en=%b req=%b expected 1/0", core_en, mem_req); end
    pc_out = 32'h4;
    step();
    checks++; if (core_en !== 1'b0 || mem_req !== 1'b1) begin errors++; $display("FAIL alu_next_fetch: got en=%b req=%b expected 0/1", core_en, mem_req); end
    checks++; if (mem_addr !== 32'h4) begin errors++; $display("FAIL alu_next_addr: got %h expected 4", mem_addr); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL alu_retired: got %0d expected 1", retired); end
  endtask

  task automatic test_ldr();
    mem_rdata = c_LDR; mem_ready = 1'b1; MRE = 1'b1; memdir = 32'h100;
    step();
    mem_ready = 1'b0; mem_rdata = 32'h0BAD_0BAD;
    checks++; if (mem_req !== 1'b0 || instruction !== c_LDR) begin errors++; $display("FAIL ldr_exec: got req=%b instr=%h expected 0/%h", mem_req, instruction, c_LDR); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin errors++; $display("FAIL ldr_data_req%0d: got req=%b we=%b addr=%h expected 1/0/100", i, mem_req, mem_we, mem_addr); end
    end
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_BABE;
    step();
    mem_ready = 1'b0;
    checks++; if (memdatain !== 32'hCAFE_BABE) begin errors++; $display("FAIL ldr_memdatain: got %h expected cafebabe", memdatain); end
    checks++; if (core_en !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL ldr_commit: got en=%b req=%b expected 1/0", core_en, mem_req); end
    MRE = 1'b0; pc_out = 32'h8;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8 || retired !== 32'd2) begin errors++; $display("FAIL ldr_next: got req=%b addr=%h ret=%0d expected 1/8/2", mem_req, mem_addr, retired); end
  endtask

  task automatic test_str();
    mem_rdata = c_STR; mem_ready = 1'b1; MWE = 1'b1; memdir = 32'h204; memdataout = 32'h1234_5678;
    step();
    mem_ready = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL str_exec: got req=%b expected 0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h204) begin errors++; $display("FAIL str_req: got req=%b we=%b addr=%h expected 1/1/204", mem_req, mem_we, mem_addr); end
    checks++; if (mem_wdata !== 32'h1234_5678) begin errors++; $display("FAIL str_wdata: got %h expected 12345678", mem_wdata); end
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    mem_ready = 1'b0;
    checks++; if (core_en !== 1'b1) begin errors++; $display("FAIL str_commit: got %b expected 1", core_en); end
    checks++; if (memdatain !== 32'hCAFE_BABE) begin errors++; $display("FAIL str_memdatain_kept: got %h expected cafebabe", memdatain); end
    MWE = 1'b0; pc_out = 32'hC;
    step();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'hC) begin errors++; $display("FAIL str_next: got req=%b we=%b addr=%h expected 1/0/c", mem_req, mem_we, mem_addr); end
  endtask

  task automatic test_halt();
    mem_rdata = c_LDR; mem_ready = 1'b1; MRE = 1'b1; memdir = 32'h40;
    step();
    mem_ready = 1'b0;
    step();
    halt_req = 1'b1;
    step();
    mem_ready = 1'b1; mem_rdata = 32'h0000_0011;
    step();
    mem_ready = 1'b0;
    checks++; if (core_en !== 1'b1 || memdatain !== 32'h11) begin errors++; $display("FAIL halt_commit: got en=%b data=%h expected 1/11", core_en, memdatain); end
    MRE = 1'b0; pc_out = 32'h10;
    step();
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b req=%b en=%b expected 1/0/0", halted, mem_req, core_en); end
    step();
    checks++; if (halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL halt_hold: got halted=%b req=%b expected 1/0", halted, mem_req); end
    halt_req = 1'b0;
    step();
    checks++; if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected 0/1/10", halted, mem_req, mem_addr); end
  endtask

  task automatic test_exec_conflict();
    mem_rdata = c_LDR; mem_ready = 1'b1; MRE = 1'b1; MWE = 1'b1;
    step();
    mem_ready = 1'b0;
    step();
    checks++; if (err !== 2'b11 || halted !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL conflict_err: got err=%b halted=%b req=%b expected 11/1/0", err, halted, mem_req); end
    step(); step();
    checks++; if (err !== 2'b11 || core_en !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL conflict_sticky: got err=%b en=%b req=%b expected 11/0/0", err, core_en, mem_req); end
    MRE = 1'b0; MWE = 1'b0;
  endtask

  task automatic test_timeout();
    int bad = 0;
    int n = 0;
    reset = 1'b0; pc_out = 32'h20;
    step();
    reset = 1'b1;
    step();
    for (int i = 1; i < 15; i++) begin
      mem_ready = 1'b0;
      step();
      if (mem_req !== 1'b1 || err !== 2'b00) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles expected 0", bad); end
    mem_ready = 1'b1; mem_rdata = c_ALU;
    step();
    mem_ready = 1'b0;
    checks++; if (err !== 2'b00 || halted !== 1'b0 || instruction !== c_ALU) begin errors++; $display("FAIL tmo_late_ready: got err=%b halted=%b instr=%h expected 00/0/%h", err, halted, instruction, c_ALU); end
    step(); step();
    while (halted !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++; if (halted !== 1'b1 || err !== 2'b01 || mem_req !== 1'b0) begin errors++; $display("FAIL tmo_fetch_err: got halted=%b err=%b req=%b expected 1/01/0", halted, err, mem_req); end
    checks++; if (n < 15 || n > 17) begin errors++; $display("FAIL tmo_length: got %0d cycles expected 15..17", n); end
    step(); step(); step();
    checks++; if (err !== 2'b01 || halted !== 1'b1 || mem_req !== 1'b0 || core_en !== 1'b0) begin errors++; $display("FAIL tmo_sticky: got err=%b halted=%b req=%b en=%b expected 01/1/0/0", err, halted, mem_req, core_en); end
  endtask

  task automatic test_reset_mid_data();
    reset = 1'b0; pc_out = 32'h0;
    step();
    reset = 1'b1;
    step();
    test_alu();
    mem_rdata = c_LDR; mem_ready = 1'b1; MRE = 1'b1; memdir = 32'h300;
    step();
    mem_ready = 1'b0;
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h300 || retired !== 32'd1) begin errors++; $display("FAIL rmd_in_data: got req=%b addr=%h ret=%0d expected 1/300/1", mem_req, mem_addr, retired); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmd_req_async: got %b expected 0", mem_req); end
    checks++; if (retired !== 32'd0 || instruction !== 32'h0 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmd_regs: got ret=%h instr=%h addr=%h expected 0/0/0", retired, instruction, mem_addr); end
    checks++; if ({core_en, halted, mem_we, err} !== 5'b0) begin errors++; $display("FAIL rmd_flags: got %b expected 00000", {core_en, halted, mem_we, err}); end
    step();
    reset = 1'b1; MRE = 1'b0; pc_out = 32'h40;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rmd_idle: got %b expected 0", mem_req); end
    step();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL rmd_refetch: got req=%b addr=%h expected 1/40", mem_req, mem_addr); end
  endtask

  initial begin
    reset = 1'b0; pc_out = '0; MRE = 1'b0; MWE = 1'b0; memdir = '0; memdataout = '0;
    mem_rdata = '0; mem_ready = 1'b0; halt_req = 1'b0;
    test_reset();
    test_alu();
    test_ldr();
    test_str();
    test_halt();
    test_exec_conflict();
    test_timeout();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
